lab2_proc_imul_arb: RTL and testbench
=====================================

LAB2_PROC_IMUL_ARB -- requirements
Module: lab2_proc_imul_arb

Interface
REQ-001 Parameter: p_num_reqs, default 2, number of requesters sharing one iterative multiplier; legal range 2..4.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_val  input  p_num_reqs  per-requester request valid.
REQ-005 Port: req_rdy  output  p_num_reqs  per-requester request ready.
REQ-006 Port: req_msg  input  64*p_num_reqs  per-requester operands; slice i is {op1[63:32], op2[31:0]}.
REQ-007 Port: resp_val  output  p_num_reqs  per-requester response valid.
REQ-008 Port: resp_rdy  input  p_num_reqs  per-requester response ready.
REQ-009 Port: resp_msg  output  32  product, broadcast to all requesters; meaningful only where resp_val is set.
REQ-010 Port: mul_req_val / mul_req_rdy / mul_req_msg  output / input / output  1/1/64  request stream to the multiplier.
REQ-011 Port: mul_resp_val / mul_resp_rdy / mul_resp_msg  input / output / input  1/1/32  response stream from the multiplier.
REQ-012 Port: busy  output  1  high while a transaction is outstanding.

Function
REQ-013 The block SHALL have two states: IDLE (no outstanding transaction) and BUSY (one transaction outstanding, owner recorded).
REQ-014 At most one transaction SHALL be outstanding at any time.
REQ-015 In IDLE, grant SHALL be combinational round-robin: the first requester with req_val set, searching from ptr upward with wrap modulo p_num_reqs.
REQ-016 In IDLE: mul_req_val = |req_val; mul_req_msg = granted slice; req_rdy[g] = mul_req_rdy for the granted g only; all other req_rdy = 0.
REQ-017 Request fire (mul_req_val & mul_req_rdy) SHALL latch owner <= g, set ptr <= (g+1) mod p_num_reqs, and move to BUSY.
REQ-018 In BUSY: req_rdy = 0 and mul_req_val = 0, except as allowed by REQ-027.
REQ-019 In BUSY: resp_val[owner] = mul_resp_val; other resp_val = 0; mul_resp_rdy = resp_rdy[owner]; resp_msg = mul_resp_msg.
REQ-020 Response fire (mul_resp_val & resp_rdy[owner]) SHALL return the FSM to IDLE.
REQ-021 A requester's resp_rdy low SHALL hold the multiplier output; no response is dropped or duplicated.
REQ-022 In IDLE, mul_resp_rdy = 0 and all resp_val = 0.
REQ-023 busy = (state == BUSY).
REQ-024 ptr SHALL change only on request fire; a requester deasserting req_val before grant SHALL NOT change ptr.
REQ-025 Latency: arbiter adds zero cycles on request and response paths; both are pure pass-through gated by state.

Reset
REQ-026 While reset is high on a clock edge: state <= IDLE, owner <= 0, ptr <= 0; during the reset cycle all req_rdy, resp_val, mul_req_val and mul_resp_rdy SHALL be 0. Reset mid-transaction abandons the transaction; the multiplier is reset by the same signal.

Configuration
REQ-027 Macro LAB2_PROC_IMUL_ARB_BYPASS_EN defined: in BUSY, on the cycle of response fire, a new grant SHALL be arbitrated per REQ-015/016 and may fire the same cycle (BUSY->BUSY, new owner, ptr updated). Macro undefined: at least one IDLE cycle SHALL separate a response fire from the next request fire.

Verification
REQ-028 Single requester: req0 issues 3 x 7 after reset -> mul_req_msg = {32'd3,32'd7}; resp_val[0] with resp_msg = 21; resp_val[1] never set.
REQ-029 Contention: req_val = 2'b11 held in IDLE after reset -> requester 0 is granted first, then requester 1, alternating 0,1,0,1 for 4 transactions.
REQ-030 Backpressure: resp_rdy[1] = 0 for 10 cycles while its product 0xFFFFFFFF*2 is ready -> mul_resp_rdy = 0, state stays BUSY, req_rdy = 0 throughout; resp_msg = 0xFFFFFFFE delivered after release.
REQ-031 Back-to-back, LAB2_PROC_IMUL_ARB_BYPASS_EN defined and undefined: both requests pending -> with the macro, the second request fires in the same cycle as the first response; without it, exactly one idle cycle separates them.
REQ-032 Reset mid-operation: assert reset while BUSY with owner = 1 -> next cycle is IDLE, ptr = 0, all val/rdy outputs 0, and a subsequent request from requester 0 is granted.
REQ-033 p_num_reqs = 4, req_val = 4'b1001 with ptr = 1 -> requester 3 is granted, and ptr becomes 0.

Source files
------------

// File: rtl/lab2_proc_imul_arb.sv
// rtl/lab2_proc_imul_arb.sv - round-robin arbiter sharing one iterative multiplier among requesters
// Optional macro LAB2_PROC_IMUL_ARB_BYPASS_EN: re-arbitrate on the response-fire cycle (BUSY->BUSY).
module lab2_proc_imul_arb #(
  parameter int p_num_reqs = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [p_num_reqs-1:0]   req_val,
  output logic [p_num_reqs-1:0]   req_rdy,
  input  logic [64*p_num_reqs-1:0] req_msg,
  output logic [p_num_reqs-1:0]   resp_val,
  input  logic [p_num_reqs-1:0]   resp_rdy,
  output logic [31:0]             resp_msg,
  output logic                    mul_req_val,
  input  logic                    mul_req_rdy,
  output logic [63:0]             mul_req_msg,
  input  logic                    mul_resp_val,
  output logic                    mul_resp_rdy,
  input  logic [31:0]             mul_resp_msg,
  output logic                    busy
);

  localparam int c_iw = (p_num_reqs > 2) ? 2 : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [c_iw-1:0] r_owner;
  logic [c_iw-1:0] w_owner_nxt;
  logic [c_iw-1:0] r_ptr;
  logic [c_iw-1:0] w_ptr_nxt;
  logic [c_iw-1:0] w_grant;
  logic [c_iw-1:0] w_ptr_inc;
  logic            w_any;
  logic            w_arb_en;
  logic            w_resp_fire;
  logic [63:0]     w_grant_msg;
  int              w_dist;
  int              w_best;

  // Round-robin: pick the requester with the smallest distance from ptr, wrapping upward.
  always_comb begin
    w_grant     = r_ptr;
    w_grant_msg = '0;
    w_best      = p_num_reqs;
    w_dist      = 0;
    w_any       = |req_val;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (i >= int'(r_ptr)) w_dist = i - int'(r_ptr);
      else                  w_dist = i + p_num_reqs - int'(r_ptr);
      if (req_val[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_grant = c_iw'(i);
      end
    end
    for (int i = 0; i < p_num_reqs; i++) begin
      if (w_grant == c_iw'(i)) w_grant_msg = req_msg[64*i +: 64];
    end
  end

  assign w_ptr_inc = (w_grant == c_iw'(p_num_reqs - 1)) ? '0 : w_grant + c_iw'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_arb_en     = 1'b0;
    w_resp_fire  = 1'b0;
    req_rdy      = '0;
    resp_val     = '0;
    mul_req_val  = 1'b0;
    mul_resp_rdy = 1'b0;
    mul_req_msg  = w_grant_msg;
    resp_msg     = mul_resp_msg;
    if (!reset) begin
      case (r_state)
        ST_IDLE: w_arb_en = 1'b1;
        ST_BUSY: begin
          resp_val[r_owner] = mul_resp_val;
          mul_resp_rdy      = resp_rdy[r_owner];
          w_resp_fire       = mul_resp_val & resp_rdy[r_owner];
          if (w_resp_fire) w_state_nxt = ST_IDLE;
`ifdef LAB2_PROC_IMUL_ARB_BYPASS_EN
          w_arb_en = w_resp_fire;
`endif
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      // Request path is a pure pass-through of the granted slice while arbitration is open.
      if (w_arb_en) begin
        mul_req_val      = w_any;
        req_rdy[w_grant] = mul_req_rdy & w_any;
        if (w_any && mul_req_rdy) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_grant;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign busy = (r_state == ST_BUSY);

endmodule

// File: tb/tb_lab2_proc_imul_arb.sv
// tb/tb_lab2_proc_imul_arb.sv - self-checking bench for lab2_proc_imul_arb (2- and 4-requester builds)
// Honours LAB2_PROC_IMUL_ARB_BYPASS_EN for the back-to-back expectations.
module tb_lab2_proc_imul_arb;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
  logic [64*N-1:0] req_msg;
  logic [31:0]     resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, busy;
  logic [63:0]     mul_req_msg;
  logic [31:0]     mul_resp_msg;

  lab2_proc_imul_arb #(.p_num_reqs(N)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .busy(busy)
  );

  logic         reset4;
  logic [3:0]   r4_val, r4_rdy, r4_resp_val, r4_resp_rdy;
  logic [255:0] r4_msg;
  logic [31:0]  r4_resp_msg, m4_resp_msg;
  logic         m4_req_val, m4_req_rdy, m4_resp_val, m4_resp_rdy, busy4;
  logic [63:0]  m4_req_msg;

  lab2_proc_imul_arb #(.p_num_reqs(4)) dut4 (
    .clk(clk), .reset(reset4),
    .req_val(r4_val), .req_rdy(r4_rdy), .req_msg(r4_msg),
    .resp_val(r4_resp_val), .resp_rdy(r4_resp_rdy), .resp_msg(r4_resp_msg),
    .mul_req_val(m4_req_val), .mul_req_rdy(m4_req_rdy), .mul_req_msg(m4_req_msg),
    .mul_resp_val(m4_resp_val), .mul_resp_rdy(m4_resp_rdy), .mul_resp_msg(m4_resp_msg),
    .busy(busy4)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requesters: each holds req_val while it still has requests left to issue.
  int          rq_cnt[N];
  logic [31:0] op1[N], op2[N];
  always @(posedge clk) begin : drv
    logic [N-1:0] f;
    f = req_val & req_rdy;
    #1;
    for (int i = 0; i < N; i++) begin
      if (f[i] && rq_cnt[i] > 0) rq_cnt[i]--;
      req_val[i] = (rq_cnt[i] > 0);
      req_msg[64*i +: 64] = {op1[i], op2[i]};
    end
  end

  // Multiplier stand-in: fixed latency, queued results, reset with the arbiter.
  int          mul_lat = 2;
  logic [31:0] mq_prod[$];
  int          mq_cnt[$];
  always @(posedge clk) begin : mul_model
    bit rqf, rsf, rst;
    logic [63:0] m;
    rqf = mul_req_val && mul_req_rdy;
    rsf = mul_resp_val && mul_resp_rdy;
    rst = reset;
    m   = mul_req_msg;
    #1;
    if (rst) begin
      mq_prod.delete();
      mq_cnt.delete();
    end else begin
      if (rsf) begin
        void'(mq_prod.pop_front());
        void'(mq_cnt.pop_front());
      end
      for (int i = 0; i < mq_cnt.size(); i++) if (mq_cnt[i] > 0) mq_cnt[i]--;
      if (rqf) begin
        mq_prod.push_back(m[63:32] * m[31:0]);
        mq_cnt.push_back(mul_lat - 1);
      end
    end
    mul_resp_val = (mq_cnt.size() > 0) && (mq_cnt[0] == 0);
    mul_resp_msg = (mq_prod.size() > 0) ? mq_prod[0] : 32'd0;
  end

  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference model: outstanding flag, owner, pointer, and the product each owner is owed.
  bit          mb = 1'b0;
  int          mo = 0;
  int          mp = 0;
  logic [31:0] exp_prod[N];
  int          g_log[$];
  int          rqf_cyc[$];
  logic [63:0] rqm_log[$];
  int          rs_own[$];
  logic [31:0] rs_msg[$];
  int          rsf_cyc[$];

  always @(negedge clk) begin : compare
    logic [N-1:0] e_rq_rdy, e_rs_val;
    bit e_mrv, e_mrr, arb, rsf, rqf;
    int g;
    e_rq_rdy = '0; e_rs_val = '0; e_mrv = 0; e_mrr = 0; rsf = 0; rqf = 0;
    if (reset) begin
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_mul_req_val", mul_req_val, 0);
      chk("rst_mul_resp_rdy", mul_resp_rdy, 0);
      chk("rst_busy", busy, mb);
      mb = 0; mo = 0; mp = 0;
    end else begin
      arb = !mb;
      if (mb) begin
        e_rs_val[mo] = mul_resp_val;
        e_mrr        = resp_rdy[mo];
        rsf          = mul_resp_val && resp_rdy[mo];
        if (mul_resp_val) chk("resp_msg", resp_msg, mul_resp_msg);
        if (rsf) chk("product", resp_msg, exp_prod[mo]);
`ifdef LAB2_PROC_IMUL_ARB_BYPASS_EN
        arb = rsf;
`endif
      end
      g = rr(req_val, mp);
      if (arb && g >= 0) begin
        e_mrv       = 1;
        e_rq_rdy[g] = mul_req_rdy;
        rqf         = mul_req_rdy;
        chk("mul_req_msg", mul_req_msg, req_msg[64*g +: 64]);
      end
      chk("req_rdy", req_rdy, e_rq_rdy);
      chk("resp_val", resp_val, e_rs_val);
      chk("mul_req_val", mul_req_val, e_mrv);
      chk("mul_resp_rdy", mul_resp_rdy, e_mrr);
      chk("busy", busy, mb);
      if (rsf) mb = 0;
      if (rqf) begin
        mb = 1; mo = g; mp = (g + 1) % N;
        exp_prod[g] = req_msg[64*g+32 +: 32] * req_msg[64*g +: 32];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_val[i] && req_rdy[i]) begin
        g_log.push_back(i); rqf_cyc.push_back(cyc); rqm_log.push_back(mul_req_msg);
      end
      if (resp_val[i] && resp_rdy[i]) begin
        rs_own.push_back(i); rs_msg.push_back(resp_msg); rsf_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    g_log.delete(); rqf_cyc.delete(); rqm_log.delete();
    rs_own.delete(); rs_msg.delete(); rsf_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1;
    for (int i = 0; i < N; i++) rq_cnt[i] = 0;
    resp_rdy = '1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    clear_logs();
  endtask

  task automatic wait_resps(input int n);
    int k = 0;
    while (rs_own.size() < n && k < 400) begin
      @(negedge clk); #1; k++;
    end
    chk("resp_count_reached", (rs_own.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; reset4 = 1;
    resp_rdy = '1; mul_req_rdy = 1;
    req_val = '0; req_msg = '0;
    mul_resp_val = 0; mul_resp_msg = '0;
    for (int i = 0; i < N; i++) begin rq_cnt[i] = 0; op1[i] = 0; op2[i] = 0; end
    r4_val = '0; r4_msg = '0; r4_resp_rdy = 4'hF; m4_req_rdy = 1; m4_resp_val = 0; m4_resp_msg = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_mul_req_val", mul_req_val, 0);
    chk("lit_rst_req_rdy", req_rdy, 0);
    @(posedge clk); #2 reset = 0;

    // Single requester: 3 x 7
    op1[0] = 3; op2[0] = 7; rq_cnt[0] = 1;
    wait_resps(1);
    repeat (5) @(negedge clk);
    #1;
    chk("single_req_msg", rqm_log[0], {32'd3, 32'd7});
    chk("single_owner", rs_own[0], 0);
    chk("single_product", rs_msg[0], 32'd21);
    chk("single_no_dup", rs_own.size(), 1);

    // Contention: both held, alternating grants
    do_reset();
    op1[0] = 5; op2[0] = 6; op1[1] = 9; op2[1] = 10;
    rq_cnt[0] = 2; rq_cnt[1] = 2;
    wait_resps(4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", g_log[i], i % 2);
      chk("cont_owner", rs_own[i], i % 2);
      chk("cont_product", rs_msg[i], (i % 2) ? 32'd90 : 32'd30);
    end
`ifdef LAB2_PROC_IMUL_ARB_BYPASS_EN
    chk("b2b_gap", rqf_cyc[1] - rsf_cyc[0], 0);
`else
    chk("b2b_gap", rqf_cyc[1] - rsf_cyc[0], 1);
`endif

    // Backpressure on requester 1
    do_reset();
    @(posedge clk); #2 resp_rdy = 2'b01;
    op1[1] = 32'hFFFF_FFFF; op2[1] = 2; rq_cnt[1] = 1;
    begin
      int k = 0;
      while (!mul_resp_val && k < 50) begin @(negedge clk); #1; k++; end
    end
    chk("bp_product_ready", mul_resp_val, 1);
    op1[0] = 4; op2[0] = 4; rq_cnt[0] = 1;
    repeat (10) begin
      @(negedge clk); #1;
      chk("bp_mul_resp_rdy", mul_resp_rdy, 0);
      chk("bp_busy", busy, 1);
      chk("bp_req_rdy", req_rdy, 2'b00);
      chk("bp_resp_val", resp_val, 2'b10);
    end
    @(posedge clk); #2 resp_rdy = 2'b11;
    wait_resps(2);
    chk("bp_owner", rs_own[0], 1);
    chk("bp_product", rs_msg[0], 32'hFFFF_FFFE);
    chk("bp_next_owner", rs_own[1], 0);
    chk("bp_next_product", rs_msg[1], 32'd16);

    // Reset while requester 1 owns the multiplier
    do_reset();
    @(posedge clk); #2 resp_rdy = 2'b00;
    op1[1] = 2; op2[1] = 3; rq_cnt[1] = 1;
    begin
      int k = 0;
      while (!busy && k < 50) begin @(negedge clk); #1; k++; end
    end
    chk("mid_busy", busy, 1);
    chk("mid_owner_grant", g_log[0], 1);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    @(negedge clk); #1;
    chk("mid_after_busy", busy, 0);
    chk("mid_after_resp_val", resp_val, 2'b00);
    chk("mid_after_mul_req_val", mul_req_val, 0);
    chk("mid_after_mul_resp_rdy", mul_resp_rdy, 0);
    clear_logs();
    resp_rdy = 2'b11;
    op1[0] = 7; op2[0] = 8; rq_cnt[0] = 1; rq_cnt[1] = 1;
    wait_resps(2);
    chk("mid_regrant0", g_log[0], 0);
    chk("mid_regrant0_product", rs_msg[0], 32'd56);

    // Four requesters: ptr = 1 with 4'b1001 grants requester 3, then ptr wraps to 0
    for (int i = 0; i < 4; i++) r4_msg[64*i +: 64] = {32'(i + 1), 32'(i + 10)};
    @(posedge clk); #2 reset4 = 0; r4_val = 4'b0001;
    @(negedge clk);
    chk("n4_first_rdy", r4_rdy, 4'b0001);
    @(posedge clk); #2 r4_val = 4'b0000; m4_resp_val = 1; m4_resp_msg = 32'd11;
    @(negedge clk);
    chk("n4_busy", busy4, 1);
    chk("n4_resp_val0", r4_resp_val, 4'b0001);
    @(posedge clk); #2 m4_resp_val = 0; r4_val = 4'b1001;
    @(negedge clk);
    chk("n4_grant3_rdy", r4_rdy, 4'b1000);
    chk("n4_grant3_msg", m4_req_msg, {32'd4, 32'd13});
    @(posedge clk); #2 r4_val = 4'b0000; m4_resp_val = 1;
    @(negedge clk);
    chk("n4_resp_val3", r4_resp_val, 4'b1000);
    @(posedge clk); #2 m4_resp_val = 0; r4_val = 4'b1001;
    @(negedge clk);
    chk("n4_ptr_wrap_rdy", r4_rdy, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
